// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED event sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  // Widest LED bank the mask generator can describe.
  localparam int MAX_LEDS = 64;

  // Position counter must hold 0..num_leds inclusive for FILL.
  function automatic int pos_width(input int num_leds);
    return $clog2(num_leds + 1);
  endfunction

  // Alternating mask: odd=0 lights even-index bits, odd=1 lights odd-index bits.
  function automatic logic [MAX_LEDS-1:0] parity_mask(input logic odd);
    logic [MAX_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEDS; i++) m[i] = (i[0] == odd);
    return m;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-FF synchroniser, stability debounce and rise pulse.
module btn_conditioner #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          synced;
  logic          level_d1;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
    end else begin
      // NOTE: non-blocking so synced takes the old sync1, giving two real stages.
      sync1  <= raw;
      synced <= sync1;
    end
  end

  // Accept a change only after DEBOUNCE consecutive differing synced cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level_d1 <= 1'b0;
    else      level_d1 <= level;
  end

  assign rise = level & ~level_d1;

endmodule

// File: rtl/led_event_sequencer.sv
// LED pattern engine: ALT / CHASE / BOUNCE / FILL stepped by a prescaler
// while the run button is held; the mode button cycles patterns.
// NUM_LEDS is limited to led_seq_pkg::MAX_LEDS.
module led_event_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_inp,
  input  logic                mode_btn,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                step_tick
);

  localparam int PW = pos_width(NUM_LEDS);
  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0]           LAST_POS  = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]           FULL_CNT  = PW'(NUM_LEDS);
  localparam logic [CW-1:0]           LAST_PRE  = CW'(PRESCALE - 1);
  localparam logic [MAX_LEDS-1:0]     EVEN_FULL = parity_mask(1'b0);
  localparam logic [MAX_LEDS-1:0]     ODD_FULL  = parity_mask(1'b1);
  localparam logic [NUM_LEDS-1:0]     EVEN_MASK = EVEN_FULL[NUM_LEDS-1:0];
  localparam logic [NUM_LEDS-1:0]     ODD_MASK  = ODD_FULL[NUM_LEDS-1:0];

  logic          run;
  logic          run_rise_unused;
  logic          mode_level_unused;
  logic          mode_rise;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] pos_q, pos_d;    // CHASE/BOUNCE position, FILL count
  logic          dir_q, dir_d;    // 0 = up, 1 = down
  logic          phase_q, phase_d;
  logic [CW-1:0] pre_cnt;

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_run_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (button_inp),
    .level (run),
    .rise  (run_rise_unused)
  );

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_mode_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (mode_btn),
    .level (mode_level_unused),
    .rise  (mode_rise)
  );

  // A mode press wins over a coinciding step.
  assign step_tick = run & (pre_cnt == LAST_PRE) & ~mode_rise;

  // Prescaler: free-runs while running, parked at 0 when idle or on mode change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       pre_cnt <= '0;
    else if (mode_rise || !run || pre_cnt == LAST_PRE) pre_cnt <= '0;
    else                                            pre_cnt <= pre_cnt + CW'(1);
  end

  // Next pattern state: mode change resets to start, otherwise step on tick.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    if (mode_rise) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (step_tick) begin
      case (mode_q)
        MODE_ALT:   phase_d = ~phase_q;
        MODE_CHASE: pos_d = (pos_q == LAST_POS) ? '0 : pos_q + PW'(1);
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (pos_q == LAST_POS) begin
              dir_d = 1'b1;
              pos_d = pos_q - PW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b0;
              pos_d = pos_q + PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        MODE_FILL:  pos_d = (pos_q == FULL_CNT) ? '0 : pos_q + PW'(1);
        default:    pos_d = pos_q;
      endcase
    end
  end

  // Pattern state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_ALT;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
    end
  end

  // Decode registered state to LED drive; dark whenever not running.
  always_comb begin
    leds = '0;
    if (run) begin
      case (mode_q)
        MODE_ALT:    leds = phase_q ? ODD_MASK : EVEN_MASK;
        MODE_CHASE,
        MODE_BOUNCE: leds = NUM_LEDS'(1) << pos_q;
        MODE_FILL:   leds = ~({NUM_LEDS{1'b1}} << pos_q);
        default:     leds = '0;
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_event_sequencer.sv
// Directed bench for led_event_sequencer with NUM_LEDS=8, PRESCALE=4, DEBOUNCE=4.
module tb_led_event_sequencer;

  logic       clk;
  logic       rst;
  logic       button_inp;
  logic       mode_btn;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       step_tick;

  int total = 0;
  int bad   = 0;

  logic [7:0] seq_q[$];

  led_event_sequencer #(.NUM_LEDS(8), .PRESCALE(4), .DEBOUNCE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_inp (button_inp),
    .mode_btn   (mode_btn),
    .leds       (leds),
    .mode       (mode),
    .step_tick  (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From a step-aligned point, check each LED value for one full step
  // and that the step pulse lands in the fourth cycle.
  task automatic play(input string tag);
    foreach (seq_q[i]) begin
      chk({tag, " leds"}, 32'(leds), 32'(seq_q[i]));
      chk({tag, " quiet"}, 32'(step_tick), 32'd0);
      tick(3);
      chk({tag, " tick"}, 32'(step_tick), 32'd1);
      tick(1);
    end
  endtask

  // Hold the mode button 10 cycles; returns aligned at the new mode's start.
  task automatic press_mode();
    mode_btn = 1'b1;
    fork
      begin
        tick(10);
        mode_btn = 1'b0;
      end
    join_none
    tick(7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    button_inp = 1'b0;
    mode_btn   = 1'b0;
    tick(2);
    chk("reset leds", 32'(leds), 32'h00);
    chk("reset mode", 32'(mode), 32'd0);
    chk("reset tick", 32'(step_tick), 32'd0);
    #2 rst = 1'b1;
    tick(2);

    // ALT from power-up: dark for 6 clocks, then alternate every 4.
    button_inp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("alt latency", 32'(leds), 32'h00);
    end
    tick(1);
    seq_q = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
    play("alt");

    // CHASE full lap plus wrap, then on to pos 5.
    press_mode();
    chk("chase mode", 32'(mode), 32'd1);
    seq_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    play("chase");
    seq_q = '{8'h02, 8'h04, 8'h08, 8'h10};
    play("chase2");
    chk("chase pos5", 32'(leds), 32'h20);

    // Asynchronous reset mid-cycle, checked before the next edge.
    #3 rst = 1'b0;
    #1;
    chk("async rst leds", 32'(leds), 32'h00);
    chk("async rst mode", 32'(mode), 32'd0);
    chk("async rst tick", 32'(step_tick), 32'd0);
    tick(1);
    chk("rst held leds", 32'(leds), 32'h00);
    #2 rst = 1'b1;
    tick(5);
    chk("post rst latency", 32'(leds), 32'h00);
    tick(1);
    seq_q = '{8'h55, 8'hAA, 8'h55};
    play("post rst alt");

    // Hold: release run in CHASE while 0x08 is shown, then resume.
    press_mode();
    chk("chase2 mode", 32'(mode), 32'd1);
    seq_q = '{8'h01, 8'h02};
    play("chase3");
    chk("hold pre", 32'(leds), 32'h04);
    button_inp = 1'b0;
    tick(4);
    chk("hold at 08", 32'(leds), 32'h08);
    tick(2);
    chk("hold dark", 32'(leds), 32'h00);
    for (int i = 0; i < 8; i++) begin
      chk("hold no tick", 32'(step_tick), 32'd0);
      tick(1);
    end
    button_inp = 1'b1;
    tick(5);
    chk("resume latency", 32'(leds), 32'h00);
    tick(1);
    seq_q = '{8'h08, 8'h10};
    play("resume");

    // Collision: mode rise pulse lands on the step_tick cycle.
    tick(1);
    mode_btn = 1'b1;
    fork
      begin
        tick(10);
        mode_btn = 1'b0;
      end
    join_none
    tick(6);
    chk("collide tick", 32'(step_tick), 32'd0);
    chk("collide old mode", 32'(mode), 32'd1);
    chk("collide old leds", 32'(leds), 32'h40);
    tick(1);
    chk("collide new mode", 32'(mode), 32'd2);
    seq_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    play("bounce");

    // FILL including the all-on step and the wrap to empty.
    press_mode();
    chk("fill mode", 32'(mode), 32'd3);
    seq_q = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    play("fill");

    // Glitch shorter than the debounce window is ignored.
    mode_btn = 1'b1;
    tick(2);
    mode_btn = 1'b0;
    tick(12);
    chk("glitch mode", 32'(mode), 32'd3);

    // Mode change while idle; new mode starts fresh when run resumes.
    button_inp = 1'b0;
    tick(8);
    chk("idle dark", 32'(leds), 32'h00);
    press_mode();
    chk("idle mode", 32'(mode), 32'd0);
    chk("idle leds", 32'(leds), 32'h00);
    tick(10);
    button_inp = 1'b1;
    tick(5);
    chk("idle resume latency", 32'(leds), 32'h00);
    tick(1);
    seq_q = '{8'h55, 8'hAA};
    play("idle alt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_event_sequencer.md
Name: led_event_sequencer

Overview:
Parametrised LED pattern engine for the LaunchPad event boards, generalising the 8-LED two-group alternating blinker.
- Drives NUM_LEDS outputs while the run button is held.
- Four selectable patterns: alternate, chase, bounce and fill.
- A second button cycles the pattern mode.
- Step rate is set by a prescaler; both buttons are synchronised and debounced internally.
- Sits between the board button pins and the LED pins, one instance per event.

Parameters:
NUM_LEDS, 8, number of LED outputs (>=2)
PRESCALE, 4, clocks per pattern step while running (>=1; 1 = step every clock)
DEBOUNCE, 4, consecutive stable synced cycles required to accept a button change (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
button_inp  input  1  raw run button; pattern runs while debounced level is 1
mode_btn  input  1  raw mode button; each debounced rising edge advances mode
leds  output  NUM_LEDS  LED drive, bit 0 = led_1
mode  output  2  current mode: 0 ALT, 1 CHASE, 2 BOUNCE, 3 FILL
step_tick  output  1  one-cycle pulse on each pattern step

Behaviour:
- Reset (rst=0, async): all registers clear. leds=0, mode=ALT, step_tick=0. Internal state clears to pos=0, phase=0, dir=up, prescaler=0, debounced levels=0.
- Button conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter clears whenever synced==debounced and increments otherwise.
  - When counter==DEBOUNCE-1 and synced still differs, debounced<=synced.
  - Raw-to-debounced latency is 2+DEBOUNCE clocks. A pulse shorter than DEBOUNCE synced cycles is ignored.
  - Rise pulse = debounced & ~debounced_d1, one cycle wide.
- Prescaler:
  - While run=1: counts 0..PRESCALE-1. step_tick=1 in the cycle cnt==PRESCALE-1, then cnt<=0.
  - While run=0: cnt held at 0 and no ticks.
- Pattern state advances only on step_tick. It is held (not cleared) while run=0.
- ALT: phase toggles each step.
  - phase 0: even-index bits lit (0x55 for 8).
  - phase 1: odd-index bits lit (0xAA).
- CHASE: one-hot pos. pos increments each step and wraps from NUM_LEDS-1 to 0.
- BOUNCE: one-hot pos with dir.
  - Moving up: at pos==NUM_LEDS-1 dir flips and pos decrements.
  - Moving down: at pos==0 dir flips and pos increments.
  - Each endpoint is displayed for exactly one step.
- FILL: count 0..NUM_LEDS. leds=(1<<count)-1. count wraps from NUM_LEDS to 0.
- leds = run ? decode(mode, state) : 0. Decode is combinational from registered state and registered run. leds reflects a new state in the cycle after the step_tick edge.
- Mode change on the mode rise pulse:
  - mode advances ALT->CHASE->BOUNCE->FILL->ALT.
  - pos, phase and count clear to 0, dir=up, prescaler=0.
  - step_tick is suppressed that cycle. A mode press coinciding with a tick wins: no step is taken.
- Mode may change while run=0. The new mode shows from its start state when run resumes.
- Run press and mode press in the same cycle: both take effect. The pattern starts in the new mode at its start state.
- Reset asserted mid-sequence: immediate clear. After release, behaviour is identical to power-up.
- Position counter width is clog2(NUM_LEDS+1), sized for FILL. The wrap compare must be exact for non-power-of-two NUM_LEDS.

Decomposition:
- Package led_seq_pkg:
  - mode enum and MODE_ALT/CHASE/BOUNCE/FILL constants.
  - clog2 width helper.
  - even/odd mask generator function.
- Sub-module btn_conditioner: synchroniser, debounce and rise pulse. Parameter DEBOUNCE; outputs level and rise. Instantiated twice.
- Top module holds the prescaler, mode register, pattern state and decode.

Test Plan:
- Reset: run in CHASE at pos 5, drive rst=0 asynchronously -> leds=0x00, mode=0, step_tick=0 before the next clk edge. After release, hold button -> ALT 0x55 shown.
- ALT (NUM_LEDS=8, PRESCALE=4, DEBOUNCE=4): assert button_inp -> leds=0x00 for 6 clocks, then 0x55. Flips to 0xAA 4 clocks later, then alternates every 4 clocks with step_tick each step.
- CHASE: one mode press of 10 cycles -> mode=1. leds sequence 0x01,0x02,...,0x80,0x01 at 4-clock steps.
- BOUNCE and FILL: mode=2 -> 0x01..0x80,0x40..0x01,0x02. mode=3 -> 0x00,0x01,0x03,...,0xFF,0x00.
- Glitch and hold: mode_btn high for 2 cycles -> mode unchanged. Release button_inp in CHASE at 0x08 -> leds=0x00 and step_tick silent. Re-press -> resumes at 0x08, next step 0x10.
- Collision: time the mode press so its rise pulse lands on a step_tick cycle -> no step, mode advances, state at start, next tick after 4 clocks.
